// File: rtl/framebuffer_if.sv
// Purpose : pixel write port and bit-plane read port of the panel frame memory.
// Latency : n/a (wires only); reads return on r_dout one clock after r_en.
// Backpressure : none; both sides are always ready, no stall signals exist.
//
// Ports (master = panel controller / CPU bridge, slave = framebuffer):
//   w_en, w_buffer, w_addr, w_strb, w_din  pixel write (row-major address)
//   ctrl_bitdepth                          active bits per colour channel
//   r_en, r_buffer, r_addr, r_bit          bit-plane read request (top half)
//   r_dout                                 {R0,G0,B0,R1,G1,B1} registered result
interface framebuffer_if #(
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int BITDEPTH_MAX   = 8,
  parameter int CTRL_REG_WIDTH = 32
);
  localparam int MEM_W_ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX);
  localparam int MEM_W_DATA_WIDTH = 32;
  localparam int MEM_R_ADDR_WIDTH = MEM_W_ADDR_WIDTH - 1;
  localparam int MEM_R_DATA_WIDTH = 6;
  localparam int R_BIT_WIDTH      = (BITDEPTH_MAX > 1) ? $clog2(BITDEPTH_MAX) : 1;

  logic                          w_en;
  logic                          w_buffer;
  logic [MEM_W_ADDR_WIDTH-1:0]   w_addr;
  logic [MEM_W_DATA_WIDTH/8-1:0] w_strb;
  logic [MEM_W_DATA_WIDTH-1:0]   w_din;
  logic [CTRL_REG_WIDTH-1:0]     ctrl_bitdepth;
  logic                          r_en;
  logic                          r_buffer;
  logic [MEM_R_ADDR_WIDTH-1:0]   r_addr;
  logic [R_BIT_WIDTH-1:0]        r_bit;
  logic [MEM_R_DATA_WIDTH-1:0]   r_dout;

  modport master (
    output w_en, w_buffer, w_addr, w_strb, w_din, ctrl_bitdepth,
    output r_en, r_buffer, r_addr, r_bit,
    input  r_dout
  );

  modport slave (
    input  w_en, w_buffer, w_addr, w_strb, w_din, ctrl_bitdepth,
    input  r_en, r_buffer, r_addr, r_bit,
    output r_dout
  );
endinterface

// File: rtl/framebuffer.sv
// Purpose : double-buffered RGB frame memory; byte-strobed pixel writes, paired top/bottom bit-plane reads.
// Latency : write visible to reads issued the next cycle; read data on r_dout 1 clock after r_en.
// Backpressure : none; one write and one read accepted every cycle, r_dout holds while r_en=0.
//
// Ports:
//   clk, rst   single clock, synchronous active-high reset (clears r_dout only)
//   bus        framebuffer_if.slave: write port, depth control, read port, r_dout
module framebuffer #(
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int BITDEPTH_MAX   = 8,
  parameter int CTRL_REG_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  framebuffer_if.slave  bus
);
  localparam int MEM_W_ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX);
  localparam int MEM_W_DATA_WIDTH = 32;
  localparam int MEM_R_ADDR_WIDTH = MEM_W_ADDR_WIDTH - 1;
  localparam int MEM_R_DATA_WIDTH = 6;
  localparam int R_BIT_WIDTH      = (BITDEPTH_MAX > 1) ? $clog2(BITDEPTH_MAX) : 1;
  localparam int HALF_PIXELS      = (N_ROWS_MAX * N_COLS_MAX) / 2;
  localparam int MEM_DEPTH        = 2 * HALF_PIXELS;
  localparam int IDX_WIDTH        = MEM_R_ADDR_WIDTH + 1;

  // One pixel = three colour lanes, lane 0 = B, 1 = G, 2 = R (same order as w_din bytes).
  typedef logic [2:0][BITDEPTH_MAX-1:0] pixel_t;

  // The panel is split into a top and a bottom half held in separate RAMs so that
  // a top pixel and its bottom partner (same offset, upper address bit set) can be
  // fetched in the same cycle. Each RAM holds both buffers: index = {buffer, offset}.
  pixel_t mem_top [MEM_DEPTH];
  pixel_t mem_bot [MEM_DEPTH];

  logic                  w_bottom;
  logic [IDX_WIDTH-1:0]  w_index;
  logic [IDX_WIDTH-1:0]  r_index;

  logic [CTRL_REG_WIDTH-1:0] depth_eff;
  logic [CTRL_REG_WIDTH-1:0] plane_idx;
  logic                      plane_ok;
  logic [R_BIT_WIDTH-1:0]    plane_sel;

  logic [MEM_R_DATA_WIDTH-1:0] r_dout_q;

  // Upper write-address bit picks the half; the rest is the offset inside it.
  assign w_bottom = bus.w_addr[MEM_W_ADDR_WIDTH-1];
  assign w_index  = {bus.w_buffer, bus.w_addr[MEM_R_ADDR_WIDTH-1:0]};
  assign r_index  = {bus.r_buffer, bus.r_addr};

  // ------------------------------------------------------------------
  // Bit-plane selection.
  // Planes are MSB-aligned: with an effective depth d the shift-out engine
  // counts r_bit from 0, and the stored bit used is r_bit + (BITDEPTH_MAX - d),
  // so reduced depths drop LSBs. Depth 0 or above the maximum means full depth.
  // Indices past the top bit read as 0 rather than wrapping.
  // ------------------------------------------------------------------
  always_comb begin
    depth_eff = bus.ctrl_bitdepth;
    if ((bus.ctrl_bitdepth == '0) ||
        (bus.ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX))) begin
      depth_eff = CTRL_REG_WIDTH'(BITDEPTH_MAX);
    end
    // depth_eff never exceeds BITDEPTH_MAX here, so the subtraction cannot wrap.
    plane_idx = CTRL_REG_WIDTH'(bus.r_bit) + (CTRL_REG_WIDTH'(BITDEPTH_MAX) - depth_eff);
    plane_ok  = (plane_idx < CTRL_REG_WIDTH'(BITDEPTH_MAX));
  end

  // Only meaningful when plane_ok, which guarantees the truncation is lossless.
  assign plane_sel = plane_idx[R_BIT_WIDTH-1:0];

  // Returns {R[k], G[k], B[k]} of one pixel, or zeros for an out-of-range plane.
  function automatic logic [2:0] plane_bits(
    input pixel_t                 px,
    input logic [R_BIT_WIDTH-1:0] k,
    input logic                   ok
  );
    plane_bits = ok ? {px[2][k], px[1][k], px[0][k]} : 3'b000;
  endfunction

  // ------------------------------------------------------------------
  // Write port. Byte strobes map to colour lanes; strobe 3 (pad byte) is
  // ignored. Lanes with a clear strobe keep their contents. No reset on the
  // arrays: contents are only defined once software has written them.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && bus.w_en && !w_bottom) begin
      for (int lane = 0; lane < 3; lane++) begin
        if (bus.w_strb[lane]) begin
          mem_top[w_index][lane] <= bus.w_din[8*lane +: BITDEPTH_MAX];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.w_en && w_bottom) begin
      for (int lane = 0; lane < 3; lane++) begin
        if (bus.w_strb[lane]) begin
          mem_bot[w_index][lane] <= bus.w_din[8*lane +: BITDEPTH_MAX];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read port. The arrays are sampled at the clock edge before the write
  // port's non-blocking updates land, so a same-cycle read of a pixel being
  // written returns the old contents (read-first). Holds while r_en=0.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_q <= '0;
    end else if (bus.r_en) begin
      r_dout_q <= {plane_bits(mem_top[r_index], plane_sel, plane_ok),
                   plane_bits(mem_bot[r_index], plane_sel, plane_ok)};
    end
  end

  assign bus.r_dout = r_dout_q;

  // Pad byte, pad strobe and the upper plane-index bits carry no information.
  logic unused_bits;
  assign unused_bits = ^{bus.w_din[MEM_W_DATA_WIDTH-1:24], bus.w_strb[3],
                         plane_idx[CTRL_REG_WIDTH-1:R_BIT_WIDTH]};

endmodule

// File: tb/tb_framebuffer.sv
module tb_framebuffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  framebuffer_if fb_if ();
  framebuffer dut (.clk(clk), .rst(rst), .bus(fb_if));

  typedef struct {
    logic        w_en;
    logic        w_buf;
    logic [13:0] w_addr;
    logic [3:0]  w_strb;
    logic [31:0] w_din;
    logic [31:0] depth;
    logic        r_en;
    logic        r_buf;
    logic [12:0] r_addr;
    logic [2:0]  r_bit;
    logic [5:0]  exp;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] ref_mem [2][16384];
  logic [5:0]  ref_dout;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk_idle();
    vec_t v;
    v = '{default: '0};
    v.depth = 32'd8;
    return v;
  endfunction

  function automatic vec_t mk_w(input logic b, input logic [13:0] a, input logic [3:0] s,
                                input logic [31:0] d, input logic [5:0] e);
    vec_t v;
    v = mk_idle();
    v.w_en = 1'b1; v.w_buf = b; v.w_addr = a; v.w_strb = s; v.w_din = d; v.exp = e;
    return v;
  endfunction

  function automatic vec_t mk_r(input logic b, input logic [12:0] a, input logic [2:0] pb,
                                input logic [31:0] depth, input logic [5:0] e);
    vec_t v;
    v = mk_idle();
    v.r_en = 1'b1; v.r_buf = b; v.r_addr = a; v.r_bit = pb; v.depth = depth; v.exp = e;
    return v;
  endfunction

  // Reference: colour bit k of channel c lives at word bit 8*c+k; depth d keeps
  // the d most significant bits, so plane p reads bit p + 8 - d.
  function automatic logic [5:0] ref_read(input logic b, input logic [12:0] a,
                                          input logic [2:0] pb, input logic [31:0] depth);
    int d;
    int k;
    logic [23:0] top;
    logic [23:0] bot;
    d   = (depth == 0 || depth > 8) ? 8 : int'(depth);
    k   = int'(pb) + 8 - d;
    top = ref_mem[b][int'(a)];
    bot = ref_mem[b][int'(a) + 8192];
    if (k > 7) return 6'b000000;
    return {top[16+k], top[8+k], top[k], bot[16+k], bot[8+k], bot[k]};
  endfunction

  task automatic ref_write(input logic b, input logic [13:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    logic [23:0] word;
    word = ref_mem[b][int'(a)];
    for (int l = 0; l < 3; l++) begin
      if (s[l]) word[8*l +: 8] = d[8*l +: 8];
    end
    ref_mem[b][int'(a)] = word;
  endtask

  // Apply one vector for one clock; the model's read uses pre-write contents.
  task automatic cycle(input vec_t v);
    fb_if.w_en          = v.w_en;
    fb_if.w_buffer      = v.w_buf;
    fb_if.w_addr        = v.w_addr;
    fb_if.w_strb        = v.w_strb;
    fb_if.w_din         = v.w_din;
    fb_if.ctrl_bitdepth = v.depth;
    fb_if.r_en          = v.r_en;
    fb_if.r_buffer      = v.r_buf;
    fb_if.r_addr        = v.r_addr;
    fb_if.r_bit         = v.r_bit;
    if (rst) begin
      ref_dout = 6'b000000;
    end else begin
      if (v.r_en) ref_dout = ref_read(v.r_buf, v.r_addr, v.r_bit, v.depth);
      if (v.w_en) ref_write(v.w_buf, v.w_addr, v.w_strb, v.w_din);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [5:0] exp);
    n_checks++;
    if (fb_if.r_dout !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: r_dout=%b expected %b", name, idx, fb_if.r_dout, exp);
    end
  endtask

  initial begin
    vec_t v;
    logic [5:0] planes_a [8];
    logic [5:0] planes_b [8];
    logic [3:0] full;
    full = 4'b1111;
    // 0xAAFF11 per plane, and 0x12FF56 (top) over 0x000000 (bottom).
    planes_a = '{6'b011011, 6'b110110, 6'b010010, 6'b110110,
                 6'b011011, 6'b110110, 6'b010010, 6'b110110};
    planes_b = '{6'b010000, 6'b111000, 6'b011000, 6'b010000,
                 6'b111000, 6'b010000, 6'b011000, 6'b010000};
    ref_dout = 6'b000000;

    // ---- reset: r_dout cleared even with a read requested ----
    rst = 1'b1;
    v = mk_r(0, 0, 0, 8, 0);
    cycle(v); check("reset_during", 0, 6'b000000);
    cycle(v); check("reset_during", 1, 6'b000000);
    rst = 1'b0;
    cycle(mk_idle()); check("after_reset", 0, 6'b000000);

    // ---- a write during reset is dropped ----
    cycle(mk_w(0, 14'd100, full, 32'h0, 0));
    cycle(mk_w(0, 14'd8292, full, 32'h0, 0));
    rst = 1'b1;
    v = mk_w(0, 14'd100, full, 32'h00FF_FFFF, 0);
    v.r_en = 1'b1; v.r_addr = 13'd100;
    cycle(v); check("reset_read_ignored", 0, 6'b000000);
    rst = 1'b0;
    cycle(mk_r(0, 13'd100, 0, 8, 0)); check("reset_write_ignored", 0, 6'b000000);

    // ---- table of directed vectors (exp = r_dout after the clock) ----
    tbl.push_back(mk_w(0, 14'd0,    full, 32'h00AA_FF11, 6'b000000));
    tbl.push_back(mk_w(0, 14'd8192, full, 32'h00AA_FF11, 6'b000000));
    tbl.push_back(mk_w(0, 14'd5,    full, 32'h000F_0F0F, 6'b000000));
    tbl.push_back(mk_w(0, 14'd8197, full, 32'h00F0_F0F0, 6'b000000));
    for (int i = 0; i < 8; i++) tbl.push_back(mk_r(0, 13'd0, 3'(i), 8, planes_a[i]));
    tbl.push_back(mk_w(1, 14'd5,    full,    32'h0012_3456, 6'b110110));
    tbl.push_back(mk_w(1, 14'd5,    4'b0010, 32'h0000_FF00, 6'b110110));
    tbl.push_back(mk_w(1, 14'd5,    4'b1000, 32'hFFFF_FFFF, 6'b110110));
    tbl.push_back(mk_w(1, 14'd8197, full,    32'h0000_0000, 6'b110110));
    for (int i = 0; i < 8; i++) tbl.push_back(mk_r(1, 13'd5, 3'(i), 8, planes_b[i]));
    tbl.push_back(mk_r(0, 13'd5, 0, 8, 6'b111000));
    tbl.push_back(mk_r(0, 13'd5, 7, 8, 6'b000111));
    // reduced / clamped depth
    tbl.push_back(mk_r(0, 13'd0, 0, 4, 6'b011011));
    tbl.push_back(mk_r(0, 13'd0, 1, 4, 6'b110110));
    tbl.push_back(mk_r(0, 13'd0, 2, 4, 6'b010010));
    tbl.push_back(mk_r(0, 13'd0, 3, 4, 6'b110110));
    for (int i = 4; i < 8; i++) tbl.push_back(mk_r(0, 13'd0, 3'(i), 4, 6'b000000));
    tbl.push_back(mk_r(0, 13'd0, 1, 32'd0,         6'b110110));
    tbl.push_back(mk_r(0, 13'd0, 2, 32'd9,         6'b010010));
    tbl.push_back(mk_r(0, 13'd0, 0, 32'hFFFF_FFFF, 6'b011011));
    tbl.push_back(mk_r(0, 13'd0, 0, 32'd1,         6'b110110));
    tbl.push_back(mk_r(0, 13'd0, 1, 32'd1,         6'b000000));
    // hold while r_en=0
    tbl.push_back(mk_r(0, 13'd0, 0, 8, 6'b011011));
    v = mk_r(0, 13'd5, 1, 8, 6'b011011); v.r_en = 1'b0; tbl.push_back(v);
    v = mk_r(1, 13'd5, 7, 8, 6'b011011); v.r_en = 1'b0; tbl.push_back(v);
    // same-cycle write and read of one pixel: old, then new
    v = mk_w(0, 14'd0, full, 32'h0, 6'b011011);
    v.r_en = 1'b1; v.r_buf = 1'b0; v.r_addr = 13'd0; v.r_bit = 3'd0;
    tbl.push_back(v);
    tbl.push_back(mk_r(0, 13'd0, 0, 8, 6'b000011));
    // write to other buffer alongside a read
    v = mk_w(1, 14'd0, full, 32'h00FF_FFFF, 6'b000110);
    v.r_en = 1'b1; v.r_buf = 1'b0; v.r_addr = 13'd0; v.r_bit = 3'd1;
    tbl.push_back(v);
    // highest addresses
    tbl.push_back(mk_w(0, 14'd16383, full, 32'h00FF_FFFF, 6'b000110));
    tbl.push_back(mk_w(0, 14'd8191,  full, 32'h0000_0000, 6'b000110));
    tbl.push_back(mk_r(0, 13'd8191, 3, 8, 6'b000111));

    foreach (tbl[i]) begin
      cycle(tbl[i]);
      check("table", i, tbl[i].exp);
    end

    // ---- randomized traffic in a small window, against the model ----
    for (int b = 0; b < 2; b++)
      for (int h = 0; h < 2; h++)
        for (int lo = 0; lo < 16; lo++)
          cycle(mk_w(1'(b), {1'(h), 9'd0, 4'(lo)}, full, $urandom, 0));
    for (int i = 0; i < 400; i++) begin
      v = mk_idle();
      v.w_en   = 1'($urandom_range(0, 1));
      v.w_buf  = 1'($urandom_range(0, 1));
      v.w_addr = {1'($urandom_range(0, 1)), 9'd0, 4'($urandom_range(0, 15))};
      v.w_strb = 4'($urandom_range(0, 15));
      v.w_din  = $urandom;
      v.depth  = 32'($urandom_range(0, 10));
      v.r_en   = ($urandom_range(0, 3) != 0);
      v.r_buf  = 1'($urandom_range(0, 1));
      v.r_addr = 13'($urandom_range(0, 15));
      v.r_bit  = 3'($urandom_range(0, 7));
      cycle(v);
      check("random", i, ref_dout);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
